// File: rtl/data_mem_unit.sv
// Word data memory stage: one request at a time, fixed latency, pulsed response.
// Define DMEM_BYTE_WRITE_EN to honour wstrb lane strobes on aligned stores.
module data_mem_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   memaddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic                misalign
);

  localparam int NB = DATA_W / 8;
  localparam int IW = ADDR_W - 2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          mis_q;
  logic          access;
  logic          mem_we;
  logic [NB-1:0] lane_en;

  assign idx    = addr_q[ADDR_W-1:2];
  assign mis_q  = (addr_q[1:0] != 2'b00);
  assign access = (state == WAIT) && (cnt == 4'd0);
  // A reset edge wins over a pending access edge.
  assign mem_we = rst_n && access && we_q && !mis_q;

  assign req_ready = rst_n && (state == IDLE);

`ifdef DMEM_BYTE_WRITE_EN
  assign lane_en = wstrb_q;
`else
  assign lane_en = wstrb_q | {NB{1'b1}};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      misalign   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= memaddr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            cnt     <= LAT_M1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            misalign   <= mis_q;
            if (mis_q || we_q) rdata <= '0;
            else               rdata <= mem[idx];
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit at LATENCY=2.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  memaddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hf;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_unit #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(64), .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .memaddr(memaddr),
    .wdata(wdata),
    .wstrb(wstrb),
    .resp_valid(resp_valid),
    .rdata(rdata),
    .misalign(misalign)
  );

  task automatic xact(input logic we, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic mis,
                      output int lat);
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    memaddr   = a;
    wdata     = d;
    wstrb     = s;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 20) begin
      bad++;
      $display("FAIL accept_timeout addr=%h got no ready want ready", a);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd  = 'x;
    mis = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    rd  = rdata;
    mis = misalign;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%b want=0", req_ready);
    end
    total++;
    if ({resp_valid, misalign, rdata} !== 34'd0) begin
      bad++;
      $display("FAIL rst_outs got rv=%b mis=%b rd=%h want 0/0/0",
               resp_valid, misalign, rdata);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd;
    logic mis;
    int lat;
    xact(1'b1, 8'h10, 32'hDEADBEEF, 4'hf, rd, mis, lat);
    total++;
    if (lat !== 3 || rd !== 32'd0 || mis !== 1'b0) begin
      bad++;
      $display("FAIL store10 got lat=%0d rd=%h mis=%b want 3/0/0", lat, rd, mis);
    end
    xact(1'b0, 8'h10, 32'h0, 4'hf, rd, mis, lat);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL load_latency got=%0d want=3", lat);
    end
    total++;
    if (rd !== 32'hDEADBEEF || mis !== 1'b0) begin
      bad++;
      $display("FAIL load10 got rd=%h mis=%b want deadbeef/0", rd, mis);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL resp_pulse got rv=%b rd=%h want 0/deadbeef",
               resp_valid, rdata);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rd;
    logic mis;
    int lat;
    xact(1'b1, 8'h13, 32'h12345678, 4'hf, rd, mis, lat);
    total++;
    if (lat !== 3 || rd !== 32'd0 || mis !== 1'b1) begin
      bad++;
      $display("FAIL misalign_st got lat=%0d rd=%h mis=%b want 3/0/1", lat, rd, mis);
    end
    xact(1'b0, 8'h10, 32'h0, 4'hf, rd, mis, lat);
    total++;
    if (rd !== 32'hDEADBEEF || mis !== 1'b0) begin
      bad++;
      $display("FAIL after_misalign got rd=%h mis=%b want deadbeef/0", rd, mis);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] rdy_seen;
    int accepts;
    int resps;
    accepts = 0;
    resps = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    memaddr   = 8'h10;
    wstrb     = 4'hf;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rdy_seen[11-i] = req_ready;
      if (req_ready && req_valid) accepts++;
      if (resp_valid) begin
        resps++;
        total++;
        if (rdata !== 32'hDEADBEEF) begin
          bad++; $display("FAIL b2b_data got=%h want=deadbeef", rdata);
        end
      end
    end
    req_valid = 1'b0;
    total++;
    if (rdy_seen !== 12'b1000_1000_1000) begin
      bad++; $display("FAIL b2b_ready got=%b want=100010001000", rdy_seen);
    end
    total++;
    if (accepts !== 3 || resps !== 3) begin
      bad++;
      $display("FAIL b2b_count got acc=%0d resp=%0d want 3/3", accepts, resps);
    end
  endtask

  task automatic test_byte_write;
    logic [31:0] rd;
    logic [31:0] want;
    logic mis;
    int lat;
`ifdef DMEM_BYTE_WRITE_EN
    want = 32'hDEADAAEF;
`else
    want = 32'h0000AA00;
`endif
    xact(1'b1, 8'h10, 32'h0000AA00, 4'b0010, rd, mis, lat);
    xact(1'b0, 8'h10, 32'h0, 4'hf, rd, mis, lat);
    total++;
    if (rd !== want) begin
      bad++; $display("FAIL byte_write got=%h want=%h", rd, want);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic mis;
    int lat;
    int rv_seen;
    xact(1'b1, 8'h20, 32'h11111111, 4'hf, rd, mis, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    memaddr   = 8'h20;
    wdata     = 32'h22222222;
    wstrb     = 4'hf;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    total++;
    if (rv_seen !== 0 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got rv=%0d rd=%h want 0/0", rv_seen, rdata);
    end
    rst_n = 1'b1;
    xact(1'b0, 8'h20, 32'h0, 4'hf, rd, mis, lat);
    total++;
    if (rd !== 32'h11111111) begin
      bad++; $display("FAIL reset_mid_load got=%h want=11111111", rd);
    end
  endtask

  task automatic test_boundary;
    logic [31:0] rd;
    logic mis;
    int lat;
    xact(1'b1, 8'h00, 32'h5A5A5A5A, 4'hf, rd, mis, lat);
    xact(1'b1, 8'hFC, 32'hCAFEF00D, 4'hf, rd, mis, lat);
    xact(1'b0, 8'hFC, 32'h0, 4'hf, rd, mis, lat);
    total++;
    if (rd !== 32'hCAFEF00D || mis !== 1'b0) begin
      bad++; $display("FAIL top_word got rd=%h mis=%b want cafef00d/0", rd, mis);
    end
    xact(1'b0, 8'h00, 32'h0, 4'hf, rd, mis, lat);
    total++;
    if (rd !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL word0 got=%h want=5a5a5a5a", rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misalign();
    test_back_to_back();
    test_byte_write();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
